fmc_read_responder: RTL and testbench

- Read-side responder on the STM32 parallel bus.
- Write-side control registers accept words from the MCU; this block returns status and measurement words to the MCU on bus reads.
- Synchronizes the asynchronous CS/RD_EN strobes into CLK, decodes a 4-word address window, drives a registered read word plus a tri-state enable to the top level, and snapshots a 32-bit counter so that two 16-bit reads return a coherent value.

---
 rtl/fmc_read_responder.sv | 128 ++++++++++++
 tb/tb_fmc_read_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fmc_read_responder.sv
// Read-side responder for the MCU parallel bus: synchronizes CS/RD_EN, decodes a
// 4-word window, returns a registered word with an output enable and a coherent counter snapshot.
module fmc_read_responder #(
    parameter logic [15:0] BASE_ADDR = 16'h0010,
    parameter logic [15:0] VERSION   = 16'h2307
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CS,
    input  logic        RD_EN,
    input  logic [15:0] ADDR,
    input  logic [15:0] STATUS_IN,
    input  logic [31:0] CNT_IN,
    output logic [15:0] RD_DATA,
    output logic        RD_OE,
    output logic        RD_STROBE,
    output logic        RD_MISS
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    logic        cs_meta_q, cs_sync_q;
    logic        rd_meta_q, rd_sync_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] snap_q, snap_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_oe_q, rd_oe_d;
    logic        strobe_q, strobe_d;
    logic        miss_q, miss_d;

    logic        rd_req;
    logic [15:0] offset;
    logic        hit;

    assign rd_req = !cs_sync_q && rd_sync_q;
    // Wrapping subtraction: anything below BASE_ADDR lands far above 3.
    assign offset = addr_q - BASE_ADDR;
    assign hit    = (offset[15:2] == 14'd0);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        snap_d    = snap_q;
        rd_data_d = rd_data_q;
        rd_oe_d   = rd_oe_q;
        strobe_d  = 1'b0;
        miss_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    state_d = ST_SETUP;
                    addr_d  = ADDR;
                end
            end
            ST_SETUP: begin
                if (rd_req) begin
                    state_d = ST_DRIVE;
                    if (hit) begin
                        rd_oe_d  = 1'b1;
                        strobe_d = 1'b1;
                        case (offset[1:0])
                            2'd0: rd_data_d = STATUS_IN;
                            2'd1: begin
                                rd_data_d = CNT_IN[15:0];
                                snap_d    = CNT_IN;
                            end
                            2'd2: rd_data_d = snap_q[31:16];
                            default: rd_data_d = VERSION;
                        endcase
                    end else begin
                        // Leave the bus undriven: another slave may own this address.
                        rd_data_d = 16'h0000;
                        miss_d    = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (!rd_req) begin
                    state_d = ST_IDLE;
                    rd_oe_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            rd_meta_q <= 1'b0;
            rd_sync_q <= 1'b0;
            state_q   <= ST_IDLE;
            addr_q    <= 16'h0000;
            snap_q    <= 32'h0000_0000;
            rd_data_q <= 16'h0000;
            rd_oe_q   <= 1'b0;
            strobe_q  <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            cs_meta_q <= CS;
            cs_sync_q <= cs_meta_q;
            rd_meta_q <= RD_EN;
            rd_sync_q <= rd_meta_q;
            state_q   <= state_d;
            addr_q    <= addr_d;
            snap_q    <= snap_d;
            rd_data_q <= rd_data_d;
            rd_oe_q   <= rd_oe_d;
            strobe_q  <= strobe_d;
            miss_q    <= miss_d;
        end
    end

    assign RD_DATA   = rd_data_q;
    assign RD_OE     = rd_oe_q;
    assign RD_STROBE = strobe_q;
    assign RD_MISS   = miss_q;

endmodule

// File: tb/tb_fmc_read_responder.sv
// Directed and randomized reads against a word-level model of the read window.
module tb_fmc_read_responder;

    localparam logic [15:0] BASE = 16'h0010;
    localparam logic [15:0] VER  = 16'h2307;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        rd_en = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] status_in = 16'h0000;
    logic [31:0] cnt_in = 32'h0;
    logic [15:0] rd_data;
    logic        rd_oe, rd_strobe, rd_miss;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_snap = 32'h0;

    always #5 clk = ~clk;

    fmc_read_responder #(.BASE_ADDR(BASE), .VERSION(VER)) dut (
        .CLK(clk), .RST_N(rst_n), .CS(cs), .RD_EN(rd_en), .ADDR(addr),
        .STATUS_IN(status_in), .CNT_IN(cnt_in),
        .RD_DATA(rd_data), .RD_OE(rd_oe), .RD_STROBE(rd_strobe), .RD_MISS(rd_miss)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full read transaction: strobe, 4-edge response, optional STATUS_IN change while driving, release.
    task automatic read_check(input logic [15:0] a, input logic chg, input logic [15:0] new_status,
                              input string tag);
        logic [15:0] off;
        logic        hit;
        logic [15:0] exp_data;
        off = a - BASE;
        hit = (off < 16'd4);
        exp_data = 16'h0000;
        if (hit) begin
            if (off == 16'd0) exp_data = status_in;
            else if (off == 16'd1) begin
                exp_data = cnt_in[15:0];
                model_snap = cnt_in;
            end
            else if (off == 16'd2) exp_data = model_snap[31:16];
            else exp_data = VER;
        end
        @(negedge clk);
        addr = a; cs = 1'b0; rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 check({tag, "_pre"}, {29'd0, rd_oe, rd_strobe, rd_miss}, 32'd0);
        @(posedge clk);
        #1 check({tag, "_flags"}, {29'd0, rd_oe, rd_strobe, rd_miss}, {29'd0, hit, hit, !hit});
        check({tag, "_data"}, {16'd0, rd_data}, {16'd0, exp_data});
        if (chg) status_in = new_status;
        @(posedge clk);
        #1 check({tag, "_hold"}, {16'd0, rd_oe, rd_strobe, rd_miss, rd_data},
                 {16'd0, hit, 1'b0, 1'b0, exp_data});
        @(negedge clk);
        cs = 1'b1; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 check({tag, "_oe_late"}, {31'd0, rd_oe}, {31'd0, hit});
        @(posedge clk);
        #1 check({tag, "_release"}, {15'd0, rd_oe, rd_data}, {15'd0, 1'b0, exp_data});
    endtask

    initial begin
        logic        any;
        logic [15:0] ra;
        // Reset state
        #12;
        check("reset_outputs", {13'd0, rd_oe, rd_strobe, rd_miss, rd_data}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        read_check(16'h0013, 1'b0, 16'h0, "version");
        read_check(16'h0012, 1'b0, 16'h0, "snap_after_reset");
        cnt_in = 32'h1234_5678;
        read_check(16'h0011, 1'b0, 16'h0, "cnt_lo");
        cnt_in = 32'hAAAA_BBBB;
        read_check(16'h0012, 1'b0, 16'h0, "cnt_hi_snap");
        read_check(16'h0020, 1'b0, 16'h0, "miss_above");
        read_check(16'h000F, 1'b0, 16'h0, "miss_below");

        status_in = 16'h00F0;
        read_check(16'h0010, 1'b1, 16'h0F00, "status_held");
        read_check(16'h0010, 1'b0, 16'h0, "status_next");

        // One-cycle glitch dies in SETUP
        @(negedge clk); addr = 16'h0013; cs = 1'b0; rd_en = 1'b1;
        @(negedge clk); cs = 1'b1; rd_en = 1'b0;
        any = 1'b0;
        repeat (6) begin
            @(posedge clk); #1 any = any | rd_oe | rd_strobe | rd_miss;
        end
        check("glitch_reject", {31'd0, any}, 32'd0);

        // Bus write (RD_EN low) is ignored
        @(negedge clk); addr = 16'h0010; cs = 1'b0; rd_en = 1'b0;
        any = 1'b0;
        repeat (6) begin
            @(posedge clk); #1 any = any | rd_oe | rd_strobe | rd_miss;
        end
        check("write_ignored", {31'd0, any}, 32'd0);
        @(negedge clk); cs = 1'b1;
        repeat (2) @(posedge clk);

        // Asynchronous reset while driving
        status_in = 16'hBEEF;
        @(negedge clk); addr = 16'h0010; cs = 1'b0; rd_en = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("pre_reset_drive", {15'd0, rd_oe, rd_data}, {15'd0, 1'b1, 16'hBEEF});
        #1 rst_n = 1'b0;
        #1 check("async_reset", {15'd0, rd_oe, rd_data}, 32'd0);
        model_snap = 32'h0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("post_reset_edge3", {31'd0, rd_oe}, 32'd0);
        @(posedge clk);
        #1 check("post_reset_edge4", {15'd0, rd_oe, rd_data}, {15'd0, 1'b1, 16'hBEEF});
        @(negedge clk); cs = 1'b1; rd_en = 1'b0;
        repeat (3) @(posedge clk);
        read_check(16'h0012, 1'b0, 16'h0, "snap_cleared");

        // Randomized reads
        for (int i = 0; i < 24; i++) begin
            status_in = 16'($urandom);
            cnt_in = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 16'($urandom);
            else ra = BASE + 16'($urandom_range(0, 3));
            read_check(ra, 1'($urandom_range(0, 1)), 16'($urandom), $sformatf("rand%0d_%h", i, ra));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
